// File: rtl/cmd_queue_arb.sv
// Game-command front end: arbitrates source pulses, per-source auto-repeat and a
// gravity generator into a single FIFO that the board engine drains via valid/ready.
module cmd_queue_arb #(
    parameter int               N_SRC     = 4,
    parameter int               CMD_W     = 4,
    parameter int               DEPTH     = 16,
    parameter int               REP_DELAY = 25_000_000,
    parameter int               REP_RATE  = 5_000_000,
    parameter int               GRAV_BASE = 50_000_000,
    parameter int               GRAV_STEP = 1024,
    parameter int               GRAV_MIN  = 5_000_000,
    parameter logic [CMD_W-1:0] CMD_DOWN  = CMD_W'(2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     flush,
    input  logic [N_SRC-1:0]         src_pulse,
    input  logic [N_SRC-1:0]         src_hold,
    input  logic [N_SRC*CMD_W-1:0]   src_cmd,
    input  logic [7:0]               level,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [CMD_W-1:0]         out_cmd,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
);

    localparam int          AW           = $clog2(DEPTH);
    localparam int          CW           = AW + 1;
    localparam logic [31:0] REP_DELAY_M1 = 32'(REP_DELAY - 1);
    localparam logic [31:0] REP_RATE_M1  = 32'(REP_RATE - 1);
    localparam logic [31:0] GRAV_BASE_U  = 32'(GRAV_BASE);
    localparam logic [31:0] GRAV_STEP_U  = 32'(GRAV_STEP);
    localparam logic [31:0] GRAV_MIN_U   = 32'(GRAV_MIN);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} repState_t;

    repState_t         repState_q [N_SRC];
    repState_t         repState_d [N_SRC];
    logic [31:0]       repTimer_q [N_SRC];
    logic [31:0]       repTimer_d [N_SRC];
    logic [N_SRC-1:0]  repFire;
    logic [CMD_W-1:0]  cmdOf [N_SRC];
    logic [N_SRC-1:0]  srcReq;

    logic [CMD_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        drop_q, drop_d, dropInc, nReq;
    logic [8:0]        dropSum;
    logic [31:0]       gravCnt_q, gravCnt_d, gravProd, gravPeriod;
    logic              gravReq, winValid, pushEn, popEn, full;
    logic [CMD_W-1:0]  winCmd;

    // Per-source repeat FSM; a fire still restarts the timer even if the code is 0.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            cmdOf[i]      = src_cmd[i*CMD_W +: CMD_W];
            repState_d[i] = repState_q[i];
            repTimer_d[i] = repTimer_q[i];
            repFire[i]    = 1'b0;
            if (flush || !run || !src_hold[i]) begin
                repState_d[i] = ST_IDLE;
                repTimer_d[i] = '0;
            end else begin
                case (repState_q[i])
                    ST_IDLE: begin
                        if (src_pulse[i]) begin
                            repState_d[i] = ST_DELAY;
                            repTimer_d[i] = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (repTimer_q[i] >= REP_DELAY_M1) begin
                            repFire[i]    = 1'b1;
                            repState_d[i] = ST_REPEAT;
                            repTimer_d[i] = '0;
                        end else begin
                            repTimer_d[i] = repTimer_q[i] + 32'd1;
                        end
                    end
                    ST_REPEAT: begin
                        if (repTimer_q[i] >= REP_RATE_M1) begin
                            repFire[i]    = 1'b1;
                            repTimer_d[i] = '0;
                        end else begin
                            repTimer_d[i] = repTimer_q[i] + 32'd1;
                        end
                    end
                    default: begin
                        repState_d[i] = ST_IDLE;
                        repTimer_d[i] = '0;
                    end
                endcase
            end
            srcReq[i] = (cmdOf[i] != '0) && (src_pulse[i] || repFire[i]);
        end
    end

    // Period saturates at the floor instead of wrapping when level*step exceeds the base.
    always_comb begin
        gravProd = 32'(level) * GRAV_STEP_U;
        if (gravProd >= GRAV_BASE_U || (GRAV_BASE_U - gravProd) < GRAV_MIN_U) begin
            gravPeriod = GRAV_MIN_U;
        end else begin
            gravPeriod = GRAV_BASE_U - gravProd;
        end
        gravReq = run && !flush && (gravCnt_q >= gravPeriod - 32'd1);
        if (flush || !run || gravReq) begin
            gravCnt_d = '0;
        end else begin
            gravCnt_d = gravCnt_q + 32'd1;
        end
    end

    always_comb begin
        winValid = gravReq;
        winCmd   = gravReq ? CMD_DOWN : '0;
        nReq     = gravReq ? 8'd1 : 8'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (srcReq[i] && !flush) begin
                winValid = 1'b1;
                winCmd   = cmdOf[i];
                nReq     = nReq + 8'd1;
            end
        end
    end

    // Every request that does not land in the FIFO, including a winner blocked by full, is a drop.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        popEn   = out_valid && out_ready && !flush;
        pushEn  = winValid && !flush && (!full || popEn);
        dropInc = flush ? 8'd0 : nReq - 8'(pushEn);
        dropSum = {1'b0, drop_q} + {1'b0, dropInc};
        drop_d  = dropSum[8] ? 8'hFF : dropSum[7:0];
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pushEn) tail_d = tail_q + AW'(1);
            if (popEn)  head_d = head_q + AW'(1);
            count_d = count_q + CW'(pushEn) - CW'(popEn);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            gravCnt_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                repState_q[i] <= ST_IDLE;
                repTimer_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            gravCnt_q <= gravCnt_d;
            for (int i = 0; i < N_SRC; i++) begin
                repState_q[i] <= repState_d[i];
                repTimer_q[i] <= repTimer_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) mem_q[tail_q] <= winCmd;
    end

    assign out_valid = (count_q != '0);
    assign out_cmd   = out_valid ? mem_q[head_q] : '0;
    assign count     = count_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_cmd_queue_arb.sv
// Directed bench for cmd_queue_arb: expected commands go into a scoreboard queue,
// a negedge monitor pops and compares on every accepted FIFO output.
module tb_cmd_queue_arb;

    logic        clk = 1'b0;
    logic        rst, run, flush, out_ready, out_valid;
    logic [3:0]  src_pulse, src_hold, out_cmd, cmd, monExp;
    logic [15:0] src_cmd;
    logic [7:0]  level, drop_cnt;
    logic [4:0]  count;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  expQ [$];

    cmd_queue_arb #(
        .N_SRC(4), .CMD_W(4), .DEPTH(16),
        .REP_DELAY(40), .REP_RATE(10),
        .GRAV_BASE(300), .GRAV_STEP(1), .GRAV_MIN(100),
        .CMD_DOWN(4'd2)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .flush(flush),
        .src_pulse(src_pulse), .src_hold(src_hold), .src_cmd(src_cmd),
        .level(level), .out_ready(out_ready), .out_valid(out_valid),
        .out_cmd(out_cmd), .count(count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] pulse, input logic [15:0] cmds);
        src_pulse = pulse;
        src_cmd   = cmds;
        tick();
        src_pulse = '0;
    endtask

    task automatic drainQueue(input string name);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && count != 5'd0; c++) tick();
        tick();
        out_ready = 1'b0;
        checkOutput({name, "_count"}, 32'(count), 32'd0);
        checkOutput({name, "_left"}, 32'(expQ.size()), 32'd0);
    endtask

    // A handshake seen at the negedge is the one the DUT commits on the next posedge.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL pop_unexpected: got %0d expected none", out_cmd);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("pop_cmd", 32'(out_cmd), 32'(monExp));
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1; run = 1'b0; flush = 1'b0; out_ready = 1'b0;
        src_pulse = '0; src_hold = '0; src_cmd = '0; level = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
        checkOutput("rst_cmd", 32'(out_cmd), 32'd0);
        rst = 1'b0;
        tick();

        // Two sources pulse together: lower index wins, the other is a drop.
        applyStimulus(4'b0110, 16'h0530);
        expQ.push_back(4'd3);
        checkOutput("arb_cmd", 32'(out_cmd), 32'd3);
        checkOutput("arb_valid", 32'(out_valid), 32'd1);
        checkOutput("arb_count", 32'(count), 32'd1);
        checkOutput("arb_drop", 32'(drop_cnt), 32'd1);
        drainQueue("arb");

        // Overfill: 16 accepted, 17th dropped; draining wraps the pointers.
        for (int i = 0; i < 17; i++) begin
            cmd = 4'((i % 15) + 1);
            applyStimulus(4'b0001, {12'h000, cmd});
            if (i < 16) expQ.push_back(cmd);
        end
        checkOutput("full_count", 32'(count), 32'd16);
        checkOutput("full_drop", 32'(drop_cnt), 32'd2);
        checkOutput("full_head", 32'(out_cmd), 32'd1);
        drainQueue("full");

        // Push and pop on a full FIFO both succeed.
        for (int i = 0; i < 16; i++) begin
            cmd = 4'(((i + 5) % 15) + 1);
            applyStimulus(4'b0001, {12'h000, cmd});
            expQ.push_back(cmd);
        end
        out_ready = 1'b1;
        applyStimulus(4'b0010, 16'h0070);
        expQ.push_back(4'd7);
        out_ready = 1'b0;
        checkOutput("pp_count", 32'(count), 32'd16);
        checkOutput("pp_drop", 32'(drop_cnt), 32'd2);
        drainQueue("pp");

        for (int i = 0; i < 3; i++) applyStimulus(4'b1000, 16'h4000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_drop", 32'(drop_cnt), 32'd2);

        // Auto-repeat: pulse at t=0, first repeat at 40, then every 10.
        out_ready = 1'b1;
        run = 1'b1;
        src_hold = 4'b0100;
        applyStimulus(4'b0100, 16'h0900);
        expQ.push_back(4'd9);
        for (int k = 1; k <= 95; k++) begin
            tick();
            if (k == 39) checkOutput("rep_early", 32'(count), 32'd0);
            if (k == 40) checkOutput("rep_first", 32'(count), 32'd1);
            if (k == 40 || (k > 40 && (k - 40) % 10 == 0)) expQ.push_back(4'd9);
        end
        src_hold = '0;
        run = 1'b0;
        repeat (4) tick();
        checkOutput("rep_left", 32'(expQ.size()), 32'd0);
        checkOutput("rep_drop", 32'(drop_cnt), 32'd2);

        // Gravity: 300 at level 0, floor 100 at level 255, 200 at level 100.
        level = 8'd0;
        run = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 299) checkOutput("grav0_early", 32'(out_valid), 32'd0);
        end
        checkOutput("grav0_fire", 32'(out_valid), 32'd1);
        checkOutput("grav0_cmd", 32'(out_cmd), 32'd2);
        expQ.push_back(4'd2);
        level = 8'd255;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 99) checkOutput("gravmin_early", 32'(out_valid), 32'd0);
        end
        checkOutput("gravmin_fire", 32'(out_valid), 32'd1);
        expQ.push_back(4'd2);
        level = 8'd100;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (k == 199) checkOutput("grav100_early", 32'(out_valid), 32'd0);
        end
        checkOutput("grav100_fire", 32'(out_valid), 32'd1);
        expQ.push_back(4'd2);
        run = 1'b0;
        repeat (3) tick();
        checkOutput("grav_left", 32'(expQ.size()), 32'd0);
        checkOutput("grav_drop", 32'(drop_cnt), 32'd2);

        // Async reset in the middle of a cycle with five entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd = 4'(i + 1);
            applyStimulus(4'b0001, {12'h000, cmd});
            expQ.push_back(cmd);
        end
        checkOutput("pre_rst_count", 32'(count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        expQ.delete();
        checkOutput("async_valid", 32'(out_valid), 32'd0);
        checkOutput("async_count", 32'(count), 32'd0);
        checkOutput("async_drop", 32'(drop_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
